aes_stream_sched: RTL and testbench
===================================

# aes_stream_sched

Packet-level scheduler that shares one AES block core between two 32-bit AXI-Stream requesters. It grants one requester per packet, packs four input words into a 128-bit block, and sequences the core through a start/done handshake. It then unpacks the result onto a single 32-bit AXI-Stream master tagged with the requester id. It sits between the AXI DMA-facing stream interfaces and the AES round core in the block design.

## Interface
- CNT_W, 16, width of per-requester processed-block counters
- clock  in  1  system clock; one clock domain
- reset  in  1  reset; synchronous and active-high
- s0_tdata / s1_tdata  in  32  requester words, little-endian bytes as delivered by the kernel driver
- s0_tvalid / s1_tvalid  in  1  requester word valid
- s0_tlast / s1_tlast  in  1  last word of requester packet
- s0_tready / s1_tready  out  1  word accepted when valid&ready
- m_tdata  out  32  result word
- m_tvalid  out  1  result valid
- m_tready  in  1  downstream ready
- m_tlast  out  1  last word of result packet
- m_tid  out  1  requester id of current packet (0 or 1)
- core_start  out  1  one-cycle pulse, block on core_blk_in valid
- core_blk_in  out  128  block to core, bit 127 = first byte
- core_done  in  1  one-cycle pulse, core_blk_out valid
- core_blk_out  in  128  encrypted/decrypted block
- blk_cnt0 / blk_cnt1  out  CNT_W  blocks completed per requester, wrap at 2^CNT_W
- err_misalign  out  1  sticky: a packet ended on a non-block boundary

## Operation
- Byte order: each word is byte-swapped on entry (tdata[7:0] becomes the block MSB byte). Word 0 of a block is placed at bits [127:96]. Output reverses the swap, so the bench sees the kernel's view.
- FSM states:
  - IDLE: arbitrate.
  - LOAD: accept 4 words from the granted requester.
  - RUN: pulse core_start, wait core_done.
  - DRAIN: emit 4 words.
- IDLE arbitration:
  - Only one requester valid: grant it.
  - Both valid: grant the requester not granted last (last_grant resets to 1, so s0 wins first).
  - Grant is held until the packet's tlast word has been drained.
- LOAD: tready is asserted only for the granted requester. The other requester's tready stays 0.
- tlast on word index 0–2:
  - Remaining words are zero-padded and the block proceeds.
  - err_misalign is set and stays set until reset.
  - The packet ends after this block.
- RUN: core_done is ignored in any other state.
- DRAIN:
  - m_tid = grant.
  - m_tlast is set on word 3 of the packet's final block.
  - The matching blk_cnt increments on that block's word-3 handshake.
  - Then go to LOAD if the packet continues, else IDLE.

## Timing
- Reset values: all tready, m_tvalid, m_tlast, m_tid, core_start, err_misalign are 0; blk_cnt0/1 are 0; m_tdata and core_blk_in are 0; state is IDLE.
- IDLE→LOAD takes one cycle. tready rises the cycle after grant.
- core_start pulses exactly once, the cycle after the 4th word handshake. core_blk_in is held stable until core_done.
- core_blk_out is captured on the core_done cycle. m_tvalid rises the next cycle.
- Minimum block latency, with no backpressure and a core latency of L cycles from start to done:
  - 4 cycles load.
  - 1 cycle start.
  - L cycles core.
  - 1 cycle capture.
  - 4 cycles drain.
- Under m_tready=0, m_tdata, m_tlast and m_tid hold stable.
- No new input is accepted while in RUN or DRAIN; there is no block overlap.
- Reset asserted in any state returns to IDLE on the next edge. A pending core operation is abandoned; the core shares the same reset.

## Structure
- Shared package aes_sched_pkg:
  - state enum (IDLE, LOAD, RUN, DRAIN).
  - BLK_S=128, WORD_S=32, BYTE_S=8.
  - swap_bytes32 function, reused by the benches.
- One sub-module, aes_sched_rr_arb: 2-way packet round-robin with last_grant register, req[1:0] in, gnt and gnt_valid out, advances on a pkt_done pulse.

## Test plan
- Single block, s0: key 000102…0f in core, words 0x33221100, 0x77665544, 0xbbaa9988, 0xffeeddcc with tlast → m_tdata 0xd8e0c469, 0x30047b6a, 0x80b7cdd8, 0x5ac5b470, m_tid=0, m_tlast on 4th word, blk_cnt0=1.
- Both requesters hold valid from reset, with 2-block packets each → output packet order s0, s1, s0, s1. Each packet's 8 words are contiguous with the correct m_tid.
- m_tready oscillating (2 low / 6 high) during DRAIN → no lost or duplicated words; data stable while stalled.
- s1 packet with tlast on its 2nd word → block padded with 0x00000000×2, 4 output words, m_tlast on 4th, err_misalign=1 and stays 1 after later good packets.
- Reset asserted during RUN → next cycle all outputs at reset values. A following 1-block packet completes normally with blk_cnt reset to 1.
- Force blk_cnt0 to 2^CNT_W−1, send 1 block → blk_cnt0 wraps to 0.

Source files
------------

// File: rtl/aes_sched_pkg.sv
// Shared types, sizes and the byte-swap helper for the AES stream scheduler.
package aes_sched_pkg;

  localparam int BLK_S  = 128;
  localparam int WORD_S = 32;
  localparam int BYTE_S = 8;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Reverse byte order of a word: byte 0 (bits [7:0]) becomes the MSB byte.
  function automatic logic [WORD_S-1:0] swap_bytes32(input logic [WORD_S-1:0] w);
    return {w[BYTE_S-1:0], w[2*BYTE_S-1:BYTE_S], w[3*BYTE_S-1:2*BYTE_S], w[4*BYTE_S-1:3*BYTE_S]};
  endfunction

endpackage

// File: rtl/aes_sched_rr_arb.sv
// Two-way packet round-robin arbiter. The grant is a pure function of the
// requests and the last granted requester; last_grant only moves when a
// whole packet has been drained, so a grant is never rotated mid-packet.
module aes_sched_rr_arb
  import aes_sched_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       pkt_done_i,
  input  logic       done_id_i,
  output logic       gnt_o,
  output logic       gnt_valid_o
);

  logic last_grant_q, last_grant_d;

  // Remember which requester finished the most recent packet.
  always_comb begin
    last_grant_d = last_grant_q;
    if (pkt_done_i) last_grant_d = done_id_i;
  end

  // last_grant resets to 1 so requester 0 wins the first contested round.
  always_ff @(posedge clk_i) begin
    if (rst_i) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end

  // Single requester wins outright; a tie goes to the one not granted last.
  always_comb begin
    gnt_valid_o = |req_i;
    case (req_i)
      2'b01:   gnt_o = 1'b0;
      2'b10:   gnt_o = 1'b1;
      default: gnt_o = ~last_grant_q;
    endcase
  end

endmodule

// File: rtl/aes_stream_sched.sv
// Shares one AES block core between two 32-bit stream requesters: grants a
// requester per packet, packs four words into a 128-bit block, runs the core
// through a start/done handshake and unpacks the result onto one tagged
// 32-bit output stream.
//
// Stream handshake: a word moves on a rising edge where valid and ready are
// both high. Sources hold valid and data until accepted; ready here is a
// function of the FSM state only, never of the incoming valid.
module aes_stream_sched
  import aes_sched_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_S-1:0] s0_tdata,
  input  logic              s0_tvalid,
  input  logic              s0_tlast,
  output logic              s0_tready,
  input  logic [WORD_S-1:0] s1_tdata,
  input  logic              s1_tvalid,
  input  logic              s1_tlast,
  output logic              s1_tready,
  output logic [WORD_S-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              m_tid,
  output logic              core_start,
  output logic [BLK_S-1:0]  core_blk_in,
  input  logic              core_done,
  input  logic [BLK_S-1:0]  core_blk_out,
  output logic [CNT_W-1:0]  blk_cnt0,
  output logic [CNT_W-1:0]  blk_cnt1,
  output logic              err_misalign,
  output logic [1:0]        dbg_state
);

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic [1:0]        widx_q, widx_d;
  logic [BLK_S-1:0]  blk_q, blk_d;
  logic [BLK_S-1:0]  res_q, res_d;
  logic              pkt_last_q, pkt_last_d;
  logic              start_q, start_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;

  logic              gnt, gnt_valid, pkt_done;
  logic [WORD_S-1:0] in_data;
  logic              in_valid, in_last, in_hs, out_hs;

  aes_sched_rr_arb u_arb (
    .clk_i       (clock),
    .rst_i       (reset),
    .req_i       ({s1_tvalid, s0_tvalid}),
    .pkt_done_i  (pkt_done),
    .done_id_i   (grant_q),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_valid)
  );

  // Route the granted requester onto the load path; only it sees ready.
  always_comb begin
    in_data   = grant_q ? s1_tdata  : s0_tdata;
    in_valid  = grant_q ? s1_tvalid : s0_tvalid;
    in_last   = grant_q ? s1_tlast  : s0_tlast;
    s0_tready = (state_q == LOAD) && !grant_q;
    s1_tready = (state_q == LOAD) &&  grant_q;
    in_hs     = (state_q == LOAD) && in_valid;
  end

  // Output word is taken from the captured result; word 0 sits at [127:96].
  always_comb begin
    m_tvalid = (state_q == DRAIN);
    m_tdata  = m_tvalid ? swap_bytes32(res_q[{~widx_q, 5'd0} +: WORD_S]) : '0;
    m_tlast  = m_tvalid && (widx_q == 2'd3) && pkt_last_q;
    m_tid    = m_tvalid && grant_q;
    out_hs   = m_tvalid && m_tready;
  end

  // Next-state logic: arbitrate, load a block, run the core, drain results.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    widx_d     = widx_q;
    blk_d      = blk_q;
    res_d      = res_q;
    pkt_last_d = pkt_last_q;
    start_d    = 1'b0;
    err_d      = err_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    pkt_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          grant_d    = gnt;
          state_d    = LOAD;
          widx_d     = 2'd0;
          blk_d      = '0;
          pkt_last_d = 1'b0;
        end
      end
      LOAD: begin
        if (in_hs) begin
          blk_d[{~widx_q, 5'd0} +: WORD_S] = swap_bytes32(in_data);
          if (widx_q == 2'd3 || in_last) begin
            // Words after an early tlast stay zero from the clear on entry.
            state_d    = RUN;
            start_d    = 1'b1;
            widx_d     = 2'd0;
            pkt_last_d = in_last;
            if (in_last && widx_q != 2'd3) err_d = 1'b1;
          end else begin
            widx_d = widx_q + 2'd1;
          end
        end
      end
      RUN: begin
        if (core_done) begin
          res_d   = core_blk_out;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_hs) begin
          if (widx_q == 2'd3) begin
            widx_d = 2'd0;
            if (grant_q) cnt1_d = cnt1_q + 1'b1;
            else         cnt0_d = cnt0_q + 1'b1;
            if (pkt_last_q) begin
              state_d  = IDLE;
              pkt_done = 1'b1;
            end else begin
              state_d = LOAD;
              blk_d   = '0;
            end
          end else begin
            widx_d = widx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      widx_q     <= 2'd0;
      blk_q      <= '0;
      res_q      <= '0;
      pkt_last_q <= 1'b0;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      widx_q     <= widx_d;
      blk_q      <= blk_d;
      res_q      <= res_d;
      pkt_last_q <= pkt_last_d;
      start_q    <= start_d;
      err_q      <= err_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  assign core_start   = start_q;
  assign core_blk_in  = blk_q;
  assign err_misalign = err_q;
  assign blk_cnt0     = cnt0_q;
  assign blk_cnt1     = cnt1_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_aes_stream_sched.sv
// Bench for aes_stream_sched: two randomized stream sources, a behavioural
// block core, an output sink with per-requester expected queues and counters.
module tb_aes_stream_sched;
  import aes_sched_pkg::*;

  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic [1:0]       s_tvalid, s_tlast, s_tready;
  logic [31:0]      s_tdata [2];
  logic [31:0]      m_tdata;
  logic             m_tvalid, m_tready, m_tlast, m_tid;
  logic             core_start, core_done;
  logic [127:0]     core_blk_in, core_blk_out;
  logic [CNT_W-1:0] blk_cnt0, blk_cnt1;
  logic             err_misalign;
  logic [1:0]       dbg_state;

  aes_stream_sched #(.CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .s0_tdata     (s_tdata[0]),
    .s0_tvalid    (s_tvalid[0]),
    .s0_tlast     (s_tlast[0]),
    .s0_tready    (s_tready[0]),
    .s1_tdata     (s_tdata[1]),
    .s1_tvalid    (s_tvalid[1]),
    .s1_tlast     (s_tlast[1]),
    .s1_tready    (s_tready[1]),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast),
    .m_tid        (m_tid),
    .core_start   (core_start),
    .core_blk_in  (core_blk_in),
    .core_done    (core_done),
    .core_blk_out (core_blk_out),
    .blk_cnt0     (blk_cnt0),
    .blk_cnt1     (blk_cnt1),
    .err_misalign (err_misalign),
    .dbg_state    (dbg_state)
  );

  // ---------------- environment state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int gap_pct  = 0;   // chance a source idles a cycle before presenting a word
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: 2 low / 6 high
  int core_lat = 2;   // 0 selects a random latency per block
  logic [32:0]      src_q [2][$];  // {tlast, data} per source
  logic [33:0]      exp_q [2][$];  // {block end, tlast, data} per requester
  logic [CNT_W-1:0] mcnt [2];
  logic [31:0]      pkt_w [$];
  int               order_q [$];
  bit               core_busy;
  bit               model_err;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Behavioural block core: the AES-128 known-answer vector, otherwise a
  // position-sensitive bijection so misplaced words show up.
  function automatic logic [127:0] core_fn(input logic [127:0] b);
    if (b == 128'h00112233_44556677_8899aabb_ccddeeff)
      return 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    return {b[95:0], b[127:96]} ^ 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  endfunction

  // Reference model: queue pkt_w on a source and derive the result words.
  task automatic push_pkt(input int id);
    int n, nblk;
    logic [127:0] blk, res;
    n = pkt_w.size();
    nblk = (n + 3) / 4;
    for (int i = 0; i < n; i++) src_q[id].push_back({(i == n - 1), pkt_w[i]});
    for (int b = 0; b < nblk; b++) begin
      blk = '0;
      for (int k = 0; k < 4; k++)
        if (4 * b + k < n) blk[127 - 32 * k -: 32] = swap_bytes32(pkt_w[4 * b + k]);
      res = core_fn(blk);
      for (int k = 0; k < 4; k++)
        exp_q[id].push_back({(k == 3), (b == nblk - 1) && (k == 3), swap_bytes32(res[127 - 32 * k -: 32])});
    end
    if (n % 4 != 0) model_err = 1'b1;
  endtask

  task automatic rand_pkt(input int len);
    pkt_w.delete();
    for (int i = 0; i < len; i++) pkt_w.push_back($urandom());
  endtask

  task automatic clear_model();
    for (int id = 0; id < 2; id++) begin
      src_q[id].delete();
      exp_q[id].delete();
      mcnt[id] = '0;
    end
    order_q.delete();
    model_err = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while ((src_q[0].size() + src_q[1].size() + exp_q[0].size() + exp_q[1].size()) != 0 || core_busy) begin
      @(negedge clock);
      n++;
      if (n >= max_cyc) break;
    end
    check("drain_left", src_q[0].size() + src_q[1].size() + exp_q[0].size() + exp_q[1].size(), 0);
    repeat (3) @(negedge clock);
  endtask

  task automatic check_reset_vals();
    check("rst_tready", s_tready, 2'b00);
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_m_tlast", m_tlast, 1'b0);
    check("rst_m_tid", m_tid, 1'b0);
    check("rst_core_start", core_start, 1'b0);
    check("rst_err", err_misalign, 1'b0);
    check("rst_cnt0", blk_cnt0, 0);
    check("rst_cnt1", blk_cnt1, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_blk_in", core_blk_in, 0);
    check("rst_state", dbg_state, IDLE);
  endtask

  // ---------------- driver: both sources ----------------
  initial begin
    bit took [2];
    logic [32:0] e;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata[0] = '0;
    s_tdata[1] = '0;
    took[0] = 0;
    took[1] = 0;
    forever begin
      @(negedge clock);
      for (int id = 0; id < 2; id++) begin
        if (reset) begin
          took[id] = 0;
          s_tvalid[id] = 1'b0;
        end else begin
          if (took[id]) begin
            if (src_q[id].size() > 0) void'(src_q[id].pop_front());
            s_tvalid[id] = 1'b0;
          end
          if (!s_tvalid[id] && src_q[id].size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
            e = src_q[id][0];
            s_tvalid[id] = 1'b1;
            s_tlast[id]  = e[32];
            s_tdata[id]  = e[31:0];
          end
          took[id] = s_tvalid[id] && s_tready[id];
        end
      end
    end
  end

  // ---------------- block core model ----------------
  initial begin
    logic [127:0] held;
    int cnt;
    core_done = 1'b0;
    core_blk_out = '0;
    core_busy = 0;
    held = '0;
    cnt = 0;
    forever begin
      @(negedge clock);
      core_done = 1'b0;
      if (reset) begin
        core_busy = 0;
      end else if (core_busy) begin
        check("start_once", core_start, 1'b0);
        check("tready_run", s_tready, 2'b00);
        if (cnt <= 1) begin
          check("blk_in_hold", core_blk_in, held);
          core_done = 1'b1;
          core_blk_out = core_fn(held);
          core_busy = 0;
        end else begin
          cnt--;
        end
      end else if (core_start) begin
        held = core_blk_in;
        core_busy = 1;
        cnt = (core_lat == 0) ? $urandom_range(1, 5) : core_lat;
      end
    end
  end

  // ---------------- sink / scoreboard ----------------
  initial begin
    bit stalled, cnt_chk, in_pkt;
    logic cur_tid, sv_last, sv_tid;
    logic [31:0] sv_data;
    logic [33:0] e;
    int pcnt;
    m_tready = 1'b0;
    stalled = 0; cnt_chk = 0; in_pkt = 0; cur_tid = 0; pcnt = 0;
    sv_last = 0; sv_tid = 0; sv_data = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        stalled = 0; cnt_chk = 0; in_pkt = 0;
      end else begin
        check("tready_excl", s_tready[0] & s_tready[1], 1'b0);
        if (cnt_chk) begin
          check("blk_cnt0", blk_cnt0, mcnt[0]);
          check("blk_cnt1", blk_cnt1, mcnt[1]);
          cnt_chk = 0;
        end
        if (stalled) begin
          check("hold_valid", m_tvalid, 1'b1);
          check("hold_data", m_tdata, sv_data);
          check("hold_last", m_tlast, sv_last);
          check("hold_tid", m_tid, sv_tid);
        end
        stalled = 0;
        case (rdy_mode)
          1:       m_tready = ($urandom_range(0, 99) < 70);
          2:       m_tready = ((pcnt % 8) >= 2);
          default: m_tready = 1'b1;
        endcase
        pcnt++;
        if (m_tvalid && m_tready) begin
          if (in_pkt) check("tid_contig", m_tid, cur_tid);
          else order_q.push_back(int'(m_tid));
          if (exp_q[m_tid].size() == 0) begin
            check("exp_size", exp_q[m_tid].size(), 1);
          end else begin
            e = exp_q[m_tid].pop_front();
            check("m_tdata", m_tdata, e[31:0]);
            check("m_tlast", m_tlast, e[32]);
            if (e[33]) begin
              mcnt[m_tid] = mcnt[m_tid] + 1'b1;
              cnt_chk = 1;
            end
          end
          cur_tid = m_tid;
          in_pkt = !m_tlast;
        end else if (m_tvalid) begin
          stalled = 1;
          sv_data = m_tdata;
          sv_last = m_tlast;
          sv_tid  = m_tid;
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int wait_n;
    reset = 1'b1;
    clear_model();
    repeat (3) @(negedge clock);
    check_reset_vals();
    reset = 1'b0;

    // Known-answer block on requester 0, expected words written out literally.
    gap_pct = 0; rdy_mode = 0; core_lat = 3;
    src_q[0].push_back({1'b0, 32'h33221100});
    src_q[0].push_back({1'b0, 32'h77665544});
    src_q[0].push_back({1'b0, 32'hbbaa9988});
    src_q[0].push_back({1'b1, 32'hffeeddcc});
    exp_q[0].push_back({1'b0, 1'b0, 32'hd8e0c469});
    exp_q[0].push_back({1'b0, 1'b0, 32'h30047b6a});
    exp_q[0].push_back({1'b0, 1'b0, 32'h80b7cdd8});
    exp_q[0].push_back({1'b1, 1'b1, 32'h5ac5b470});
    wait_idle(200);
    check("aes_cnt0", blk_cnt0, 1);
    check("aes_cnt1", blk_cnt1, 0);

    // Both requesters valid straight out of reset: packets alternate from s0.
    reset = 1'b1;
    @(negedge clock);
    clear_model();
    for (int p = 0; p < 2; p++)
      for (int id = 0; id < 2; id++) begin
        rand_pkt(8);
        push_pkt(id);
      end
    @(negedge clock);
    reset = 1'b0;
    wait_idle(600);
    check("order_n", order_q.size(), 4);
    for (int i = 0; i < order_q.size() && i < 4; i++) check("order", order_q[i], i % 2);
    check("rr_cnt0", blk_cnt0, 4);
    check("rr_cnt1", blk_cnt1, 4);

    // Backpressure 2 low / 6 high while draining.
    rdy_mode = 2;
    rand_pkt(8); push_pkt(0);
    rand_pkt(4); push_pkt(1);
    rand_pkt(8); push_pkt(1);
    wait_idle(800);
    rdy_mode = 0;
    check("err_clean", err_misalign, 1'b0);

    // Short packet on s1: tlast on the 2nd word pads the block.
    rand_pkt(2); push_pkt(1);
    wait_idle(200);
    check("err_set", err_misalign, 1'b1);
    rand_pkt(4); push_pkt(0);
    rand_pkt(8); push_pkt(1);
    wait_idle(400);
    check("err_sticky", err_misalign, 1'b1);

    // Randomized traffic: gaps, backpressure, variable core latency.
    gap_pct = 30; rdy_mode = 1; core_lat = 0;
    for (int p = 0; p < 16; p++) begin
      rand_pkt($urandom_range(1, 12));
      push_pkt($urandom_range(0, 1));
    end
    wait_idle(4000);
    check("err_rand", err_misalign, model_err);

    // Reset while the core is running.
    gap_pct = 0; rdy_mode = 0; core_lat = 8;
    rand_pkt(4); push_pkt(0);
    wait_n = 0;
    while (!core_busy && wait_n < 50) begin
      @(negedge clock);
      wait_n++;
    end
    check("run_reached", core_busy, 1'b1);
    @(negedge clock);
    check("in_run", dbg_state, RUN);
    reset = 1'b1;
    clear_model();
    @(negedge clock);
    check_reset_vals();
    @(negedge clock);
    reset = 1'b0;

    // A fresh single-block packet completes normally after that reset.
    core_lat = 2;
    rand_pkt(4); push_pkt(0);
    wait_idle(200);
    check("cnt_after_rst", blk_cnt0, 1);

    // Fifteen more blocks bring the counter to 2^CNT_W and it wraps to 0.
    for (int p = 0; p < 15; p++) begin
      rand_pkt(4); push_pkt(0);
    end
    wait_idle(1500);
    check("cnt_wrap", blk_cnt0, 0);
    check("cnt1_idle", blk_cnt1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
